// File: rtl/tc_chroma_sched.sv
// Chroma transform scheduler: feeds the four 4x4 sub-blocks of an 8x8 residual
// block through one shared transformcoder and reassembles the coefficients.
module tc_chroma_sched #(
    parameter int TC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0][7:0]     in_residuals,
    input  logic [5:0]           in_qp,
    output logic [15:0][7:0]     tc_residuals,
    output logic [5:0]           tc_qp,
    output logic                 tc_enable,
    input  logic                 tc_pipeline_full,
    input  logic [15:0][7:0]     tc_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0][7:0]     out_coeff0,
    output logic [15:0][7:0]     out_coeff1,
    output logic [15:0][7:0]     out_coeff2,
    output logic [15:0][7:0]     out_coeff3,
    output logic                 busy,
    output logic                 tc_err,
    output logic [CNT_W-1:0]     blk_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [63:0][7:0]   r_block;
    logic [1:0]         r_k;
    logic [15:0][7:0]   r_tc_residuals;
    logic [5:0]         r_tc_qp;
    logic [15:0][7:0]   r_coeff [4];
    logic               r_tc_err;
    logic [CNT_W-1:0]   r_blk_count;
    logic [2:0]         r_dl [TC_LATENCY];   // {valid, sub-block tag}

    logic               w_accept;
    logic               w_deliver;
    logic               w_push;
    logic               w_cap;
    logic [1:0]         w_cap_tag;

    // Sub-block k: row bit 2 comes from k[1], column bit 2 from k[0].
    function automatic logic [15:0][7:0] f_sub_block(input logic [63:0][7:0] blk,
                                                     input logic [1:0]       k);
        logic [15:0][7:0] sub;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sub[r*4+c] = blk[{k[1], r[1:0], k[0], c[1:0]}];
            end
        end
        return sub;
    endfunction

    assign w_cap_tag = r_dl[TC_LATENCY-1][1:0];
    assign w_cap     = r_dl[TC_LATENCY-1][2] && tc_enable;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // always_ff reads the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: next-state logic defaults to holding state, so no path leaves
    // w_state_nxt unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)                   w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_k == 2'd3)                w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_cap && w_cap_tag == 2'd3) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)                  w_state_nxt = S_IDLE;
            default:                                 w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = reset && (r_state == S_IDLE);
        tc_enable = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        w_push    = (r_state == S_ISSUE);
    end

    // NOTE: the held input block is pure data that is always rewritten before
    // use, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_block <= in_residuals;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k            <= 2'd0;
            r_tc_residuals <= '0;
            r_tc_qp        <= '0;
            r_tc_err       <= 1'b0;
            r_blk_count    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_coeff[i] <= '0;
            end
            for (int i = 0; i < TC_LATENCY; i++) begin
                r_dl[i] <= '0;
            end
        end else begin
            // Sub-block 0 goes straight from the input so it is presented in
            // the first issue cycle.
            if (w_accept) begin
                r_tc_qp        <= in_qp;
                r_tc_residuals <= f_sub_block(in_residuals, 2'd0);
                r_k            <= 2'd0;
            end else if (r_state == S_ISSUE) begin
                r_k            <= r_k + 2'd1;
                r_tc_residuals <= (r_k == 2'd3) ? '0 : f_sub_block(r_block, r_k + 2'd1);
            end

            r_dl[0] <= {w_push, r_k};
            for (int i = 1; i < TC_LATENCY; i++) begin
                r_dl[i] <= r_dl[i-1];
            end

            if (w_cap) begin
                r_coeff[w_cap_tag] <= tc_result;
                if (!tc_pipeline_full) begin
                    r_tc_err <= 1'b1;
                end
            end

            if (w_deliver) begin
                r_blk_count <= r_blk_count + CNT_W'(1);
            end
        end
    end

    assign tc_residuals = r_tc_residuals;
    assign tc_qp        = r_tc_qp;
    assign out_coeff0   = r_coeff[0];
    assign out_coeff1   = r_coeff[1];
    assign out_coeff2   = r_coeff[2];
    assign out_coeff3   = r_coeff[3];
    assign tc_err       = r_tc_err;
    assign blk_count    = r_blk_count;

endmodule

// File: tb/tb_tc_chroma_sched.sv
// Bench for tc_chroma_sched: an identity-delay transformcoder model plus a
// quadrant-extraction reference for expected tc inputs and coefficients.
module tb_tc_chroma_sched;

    localparam int TC_LAT = 4;
    localparam int CNT_W  = 3;

    typedef logic [63:0][7:0] blk_t;
    typedef logic [15:0][7:0] sub_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    blk_t               in_residuals;
    logic [5:0]         in_qp;
    sub_t               tc_residuals;
    logic [5:0]         tc_qp;
    logic               tc_enable;
    logic               tc_pipeline_full;
    sub_t               tc_result;
    logic               out_valid;
    logic               out_ready;
    sub_t               out_coeff0, out_coeff1, out_coeff2, out_coeff3;
    logic               busy;
    logic               tc_err;
    logic [CNT_W-1:0]   blk_count;

    tc_chroma_sched #(.TC_LATENCY(TC_LAT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_residuals     (in_residuals),
        .in_qp            (in_qp),
        .tc_residuals     (tc_residuals),
        .tc_qp            (tc_qp),
        .tc_enable        (tc_enable),
        .tc_pipeline_full (tc_pipeline_full),
        .tc_result        (tc_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_coeff0       (out_coeff0),
        .out_coeff1       (out_coeff1),
        .out_coeff2       (out_coeff2),
        .out_coeff3       (out_coeff3),
        .busy             (busy),
        .tc_err           (tc_err),
        .blk_count        (blk_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transformcoder stand-in: result is its input delayed TC_LAT cycles.
    sub_t tc_pipe [TC_LAT];
    initial for (int i = 0; i < TC_LAT; i++) tc_pipe[i] = '0;
    always @(posedge clk) begin
        tc_pipe[0] <= tc_residuals;
        for (int i = 1; i < TC_LAT; i++) tc_pipe[i] <= tc_pipe[i-1];
    end
    assign tc_result = tc_pipe[TC_LAT-1];

    int   n_checks  = 0;
    int   n_errors  = 0;
    bit   exp_err   = 1'b0;
    int   exp_count = 0;
    int   tv1, tv2;
    sub_t c3;
    blk_t blk;
    bit   seen;
    int   waited;
    int   pf_k;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic sub_t ref_sub(input blk_t b, input int k);
        sub_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r*4+c] = b[(4*(k/2)+r)*8 + 4*(k%2) + c];
        return s;
    endfunction

    function automatic sub_t dut_coeff(input int k);
        case (k)
            0:       return out_coeff0;
            1:       return out_coeff1;
            2:       return out_coeff2;
            default: return out_coeff3;
        endcase
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 64; i++) b[i] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // Entered and left at a negedge. Drives one block through the DUT.
    task automatic run_job(input blk_t b, input logic [5:0] qp, input int hold,
                           input int pfk, input bit keep_valid,
                           output int t_valid, output sub_t coeff3);
        int w = 0;
        in_residuals = b;
        in_qp        = qp;
        in_valid     = 1'b1;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1'b1);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        for (int j = 1; j <= 4 + TC_LAT; j++) begin
            tc_pipeline_full = 1'b1;
            if (pfk >= 0 && j == 1 + pfk + TC_LAT) begin
                tc_pipeline_full = 1'b0;
                exp_err          = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            check("run_tc_enable", tc_enable, 1'b1);
            check("run_busy", busy, 1'b1);
            check("run_in_ready", in_ready, 1'b0);
            check("run_out_valid", out_valid, 1'b0);
            check("run_tc_qp", tc_qp, qp);
            check("run_tc_residuals", tc_residuals, (j <= 4) ? ref_sub(b, j - 1) : sub_t'('0));
            @(negedge clk);
        end
        tc_pipeline_full = 1'b1;
        t_valid = cyc;
        check("done_out_valid", out_valid, 1'b1);
        check("done_tc_enable", tc_enable, 1'b0);
        check("done_in_ready", in_ready, 1'b0);
        check("done_tc_err", tc_err, exp_err);
        check("done_blk_count", blk_count, exp_count);
        for (int k = 0; k < 4; k++) check($sformatf("done_coeff%0d", k), dut_coeff(k), ref_sub(b, k));
        coeff3    = out_coeff3;
        out_ready = (hold == 0);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_tc_qp", tc_qp, qp);
            for (int k = 0; k < 4; k++) check($sformatf("hold_coeff%0d", k), dut_coeff(k), ref_sub(b, k));
            if (h == hold) out_ready = 1'b1;
        end
        @(negedge clk);
        exp_count = (exp_count + 1) % (1 << CNT_W);
        check("post_out_valid", out_valid, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        check("post_blk_count", blk_count, exp_count);
        check("post_tc_enable", tc_enable, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset            = 1'b0;
        in_valid         = 1'b0;
        in_residuals     = '0;
        in_qp            = '0;
        tc_pipeline_full = 1'b1;
        out_ready        = 1'b0;

        // Reset held low for two edges: everything cleared, not ready.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_tc_enable", tc_enable, 1'b0);
        check("rst_tc_residuals", tc_residuals, '0);
        check("rst_tc_qp", tc_qp, '0);
        check("rst_coeffs", {out_coeff0, out_coeff1, out_coeff2, out_coeff3} == '0, 1'b1);
        check("rst_tc_err", tc_err, 1'b0);
        check("rst_blk_count", blk_count, '0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Ramp block, QP 28.
        for (int i = 0; i < 64; i++) blk[i] = 8'(i);
        run_job(blk, 6'd28, 0, -1, 1'b0, tv1, c3);
        check("ramp_coeff3_first", c3[0], 8'd36);
        check("ramp_coeff3_last", c3[15], 8'd63);

        // Downstream back-pressure for five cycles.
        run_job(rand_blk(), 6'($urandom_range(0, 63)), 5, -1, 1'b0, tv1, c3);

        // Back-to-back with in_valid held: blocks spaced TC_LAT+6 cycles.
        run_job(rand_blk(), 6'd10, 0, -1, 1'b1, tv1, c3);
        run_job(rand_blk(), 6'd45, 0, -1, 1'b0, tv2, c3);
        check("b2b_spacing", tv2 - tv1, TC_LAT + 6);

        // Pipeline-full low while sub-block 2 is captured; error is sticky.
        run_job(rand_blk(), 6'd20, 0, 2, 1'b0, tv1, c3);
        run_job(rand_blk(), 6'd21, 1, -1, 1'b0, tv1, c3);

        // Reset in cycle 6 of a job aborts it.
        in_residuals = rand_blk();
        in_qp        = 6'd33;
        in_valid     = 1'b1;
        waited       = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("abort_accept_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_err   = 1'b0;
        exp_count = 0;
        check("abort_busy", busy, 1'b0);
        check("abort_tc_enable", tc_enable, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_tc_err", tc_err, 1'b0);
        check("abort_blk_count", blk_count, '0);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", seen, 1'b0);
        run_job(rand_blk(), 6'd17, 0, -1, 1'b0, tv1, c3);

        // Randomized jobs; blk_count wraps along the way.
        for (int n = 0; n < 10; n++) begin
            pf_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_job(rand_blk(), 6'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                    pf_k, 1'($urandom_range(0, 1)), tv1, c3);
            if (!in_valid) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("gap_in_ready", in_ready, 1'b1);
                end
            end
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
